// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator: widths, note/velocity types,
// per-voice and controller state encodings, and the note event record.
package voice_allocator_pkg;

    localparam int PIPELINE_COUNT    = 4;
    localparam int NOTE_WIDTH        = 7;
    localparam int VELOCITY_WIDTH    = 7;
    localparam int VOICE_INDEX_WIDTH = $clog2(PIPELINE_COUNT);

    typedef logic [NOTE_WIDTH-1:0]     note_t;
    typedef logic [VELOCITY_WIDTH-1:0] percent_t;

    typedef enum logic [1:0] {FREE, HELD, RELEASING} voice_state_t;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT}    alloc_state_t;

    typedef struct packed {
        logic     note_on;
        note_t    note;
        percent_t velocity;
    } note_event_t;

endpackage

// File: rtl/voice_allocator_age.sv
// Age ranking of voices: a permutation where 0 is newest. A promote strobe
// moves one voice to rank 0 and ages every voice that was newer than it.
module voice_age_tracker #(
    parameter int PIPELINE_COUNT = 4,
    parameter int INDEX_WIDTH    = $clog2(PIPELINE_COUNT)
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      promote,
    input  logic [INDEX_WIDTH-1:0]                    promote_idx,
    output logic [PIPELINE_COUNT-1:0][INDEX_WIDTH-1:0] rank
);

    logic [INDEX_WIDTH-1:0] old_rank;
    assign old_rank = rank[promote_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPELINE_COUNT; i++)
                rank[i] <= INDEX_WIDTH'(i);
        end else if (promote) begin
            for (int i = 0; i < PIPELINE_COUNT; i++) begin
                if (promote_idx == INDEX_WIDTH'(i))
                    rank[i] <= '0;
                else if (rank[i] < old_rank)
                    rank[i] <= rank[i] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note-on/off events to synthesis voices: serial scan of all voices,
// then a commit choosing retrigger > free > oldest releasing > oldest overall.
module voice_allocator #(
    parameter int PIPELINE_COUNT = voice_allocator_pkg::PIPELINE_COUNT,
    parameter int NOTE_WIDTH     = voice_allocator_pkg::NOTE_WIDTH,
    parameter int VELOCITY_WIDTH = voice_allocator_pkg::VELOCITY_WIDTH,
    parameter int INDEX_WIDTH    = $clog2(PIPELINE_COUNT)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          event_valid,
    output logic                                          event_ready,
    input  logic                                          event_note_on,
    input  logic [NOTE_WIDTH-1:0]                         event_note,
    input  logic [VELOCITY_WIDTH-1:0]                     event_velocity,
    input  logic [PIPELINE_COUNT-1:0]                     voice_done,
    output logic [PIPELINE_COUNT-1:0]                     voice_active,
    output logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0]     voice_note,
    output logic [PIPELINE_COUNT-1:0][VELOCITY_WIDTH-1:0] voice_velocity,
    output logic [PIPELINE_COUNT-1:0]                     voice_start,
    output logic [PIPELINE_COUNT-1:0]                     voice_release
);
    import voice_allocator_pkg::*;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(PIPELINE_COUNT - 1);

    alloc_state_t                             state, state_next;
    voice_state_t [PIPELINE_COUNT-1:0]        vstate;
    logic [PIPELINE_COUNT-1:0][INDEX_WIDTH-1:0] rank;

    logic [INDEX_WIDTH-1:0]    scan_idx;
    logic                      ev_on;
    logic [NOTE_WIDTH-1:0]     ev_note;
    logic [VELOCITY_WIDTH-1:0] ev_vel;

    logic                   match_found, free_found, rel_found;
    logic [INDEX_WIDTH-1:0] match_idx, free_idx, rel_idx, oldest_idx;

    logic                   commit_on, commit_off;
    logic [INDEX_WIDTH-1:0] target_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (event_valid) state_next = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign event_ready = (state == IDLE);

    always_comb begin
        commit_on  = (state == COMMIT) && ev_on;
        commit_off = (state == COMMIT) && !ev_on && match_found;
        if (match_found)     target_idx = match_idx;
        else if (free_found) target_idx = free_idx;
        else if (rel_found)  target_idx = rel_idx;
        else                 target_idx = oldest_idx;
    end

    // One voice examined per scan cycle; state seen is whatever it is that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_idx    <= '0;
            ev_on       <= 1'b0;
            ev_note     <= '0;
            ev_vel      <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            rel_idx     <= '0;
            oldest_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (event_valid) begin
                    ev_on       <= event_note_on && (event_velocity != '0);
                    ev_note     <= event_note;
                    ev_vel      <= event_velocity;
                    scan_idx    <= '0;
                    match_found <= 1'b0;
                    free_found  <= 1'b0;
                    rel_found   <= 1'b0;
                    oldest_idx  <= '0;
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (!match_found && vstate[scan_idx] != FREE &&
                        voice_note[scan_idx] == ev_note &&
                        (ev_on || vstate[scan_idx] == HELD)) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!free_found && vstate[scan_idx] == FREE) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (vstate[scan_idx] == RELEASING &&
                        (!rel_found || rank[scan_idx] > rank[rel_idx])) begin
                        rel_found <= 1'b1;
                        rel_idx   <= scan_idx;
                    end
                    if (rank[scan_idx] > rank[oldest_idx])
                        oldest_idx <= scan_idx;
                end
                default: ;
            endcase
        end
    end

    // Commit assignments come last so they override a same-cycle voice_done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vstate         <= {PIPELINE_COUNT{FREE}};
            voice_note     <= '0;
            voice_velocity <= '0;
            voice_start    <= '0;
            voice_release  <= '0;
        end else begin
            voice_start   <= '0;
            voice_release <= '0;
            for (int i = 0; i < PIPELINE_COUNT; i++)
                if (vstate[i] == RELEASING && voice_done[i]) vstate[i] <= FREE;
            if (commit_on) begin
                vstate[target_idx]         <= HELD;
                voice_note[target_idx]     <= ev_note;
                voice_velocity[target_idx] <= ev_vel;
                voice_start[target_idx]    <= 1'b1;
            end
            if (commit_off) begin
                vstate[match_idx]        <= RELEASING;
                voice_release[match_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        voice_active = '0;
        for (int i = 0; i < PIPELINE_COUNT; i++)
            voice_active[i] = (vstate[i] != FREE);
    end

    voice_age_tracker #(
        .PIPELINE_COUNT(PIPELINE_COUNT),
        .INDEX_WIDTH   (INDEX_WIDTH)
    ) u_age (
        .clock      (clock),
        .reset      (reset),
        .promote    (commit_on),
        .promote_idx(target_idx),
        .rank       (rank)
    );

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a list-based voice model predicts
// each event's pulses and resulting voice table; a monitor checks them.
module tb_voice_allocator;

    localparam int P  = 4;
    localparam int NW = 7;
    localparam int VW = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              event_valid;
    logic              event_ready;
    logic              event_note_on;
    logic [NW-1:0]     event_note;
    logic [VW-1:0]     event_velocity;
    logic [P-1:0]      voice_done;
    logic [P-1:0]      voice_active;
    logic [P-1:0][NW-1:0] voice_note;
    logic [P-1:0][VW-1:0] voice_velocity;
    logic [P-1:0]      voice_start;
    logic [P-1:0]      voice_release;

    always #10 clock = ~clock;

    voice_allocator dut (
        .clock         (clock),
        .reset         (reset),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_note_on (event_note_on),
        .event_note    (event_note),
        .event_velocity(event_velocity),
        .voice_done    (voice_done),
        .voice_active  (voice_active),
        .voice_note    (voice_note),
        .voice_velocity(voice_velocity),
        .voice_start   (voice_start),
        .voice_release (voice_release)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [P-1:0]     start;
        logic [P-1:0]     rel;
        logic [P-1:0]     active;
        logic [P*NW-1:0]  notes;
        logic [P*VW-1:0]  vels;
    } exp_t;
    exp_t sb[$];

    // Model: 0 free, 1 held, 2 releasing; m_age lists voices newest first.
    int m_state[P];
    int m_note[P];
    int m_vel[P];
    int m_age[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_age.delete();
        for (int i = 0; i < P; i++) begin
            m_state[i] = 0; m_note[i] = 0; m_vel[i] = 0;
            m_age.push_back(i);
        end
    endfunction

    function automatic logic [P-1:0] model_active();
        logic [P-1:0] a = '0;
        for (int i = 0; i < P; i++) a[i] = (m_state[i] != 0);
        return a;
    endfunction

    function automatic logic [P*NW-1:0] model_notes();
        logic [P*NW-1:0] v = '0;
        for (int i = 0; i < P; i++) v[i*NW +: NW] = m_note[i][NW-1:0];
        return v;
    endfunction

    function automatic logic [P*VW-1:0] model_vels();
        logic [P*VW-1:0] v = '0;
        for (int i = 0; i < P; i++) v[i*VW +: VW] = m_vel[i][VW-1:0];
        return v;
    endfunction

    // Applies one event (plus voice_done seen in its commit cycle) to the model.
    function automatic void model_event(input bit on, input int note, input int vel,
                                        input logic [P-1:0] done_commit, input int pulse_cyc);
        int pre[P];
        int tgt = -1;
        exp_t e;
        e.start = '0;
        e.rel   = '0;
        for (int i = 0; i < P; i++) pre[i] = m_state[i];
        if (on && vel != 0) begin
            for (int i = P - 1; i >= 0; i--) if (m_state[i] != 0 && m_note[i] == note) tgt = i;
            if (tgt < 0) for (int i = P - 1; i >= 0; i--) if (m_state[i] == 0) tgt = i;
            if (tgt < 0) for (int k = 0; k < P; k++) if (m_state[m_age[k]] == 2) tgt = m_age[k];
            if (tgt < 0) tgt = m_age[P-1];
            m_state[tgt] = 1; m_note[tgt] = note; m_vel[tgt] = vel;
            for (int k = 0; k < m_age.size(); k++)
                if (m_age[k] == tgt) begin m_age.delete(k); break; end
            m_age.push_front(tgt);
            e.start[tgt] = 1'b1;
        end else begin
            for (int i = P - 1; i >= 0; i--) if (m_state[i] == 1 && m_note[i] == note) tgt = i;
            if (tgt >= 0) begin m_state[tgt] = 2; e.rel[tgt] = 1'b1; end
        end
        for (int i = 0; i < P; i++)
            if (done_commit[i] && pre[i] == 2 && i != tgt) m_state[i] = 0;
        e.cyc    = pulse_cyc;
        e.active = model_active();
        e.notes  = model_notes();
        e.vels   = model_vels();
        if (tgt >= 0) sb.push_back(e);
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset && (voice_start != '0 || voice_release != '0)) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pulse: start=%b release=%b, expected none", voice_start, voice_release);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle",   64'(cyc),            64'(e.cyc));
                check("voice_start",   64'(voice_start),    64'(e.start));
                check("voice_release", 64'(voice_release),  64'(e.rel));
                check("voice_active",  64'(voice_active),   64'(e.active));
                check("voice_note",    64'(voice_note),     64'(e.notes));
                check("voice_vel",     64'(voice_velocity), 64'(e.vels));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_event(input bit on, input int note, input int vel, input logic [P-1:0] done_commit);
        int  w = 0;
        bit  low_ok = 1'b1;
        while (!event_ready && w < 20) begin @(negedge clock); w++; end
        if (!event_ready) check("ready_wait", 64'(event_ready), 64'd1);
        event_valid    = 1'b1;
        event_note_on  = on;
        event_note     = NW'(note);
        event_velocity = VW'(vel);
        model_event(on, note, vel, done_commit, cyc + P + 2);
        @(negedge clock);
        event_valid = 1'b0;
        for (int t = 1; t <= P + 1; t++) begin
            if (event_ready) low_ok = 1'b0;
            if (t == P + 1) voice_done = done_commit;
            @(negedge clock);
        end
        voice_done = '0;
        check("ready_low_busy", 64'(low_ok), 64'd1);
        check("ready_back", 64'(event_ready), 64'd1);
        #1;
        check("pulse_seen", 64'(sb.size()), 64'd0);
        check("active_after", 64'(voice_active), 64'(model_active()));
    endtask

    task automatic idle_done(input logic [P-1:0] mask);
        @(negedge clock);
        voice_done = mask;
        for (int i = 0; i < P; i++) if (mask[i] && m_state[i] == 2) m_state[i] = 0;
        @(negedge clock);
        voice_done = '0;
        @(negedge clock);
        check("idle_done_active", 64'(voice_active), 64'(model_active()));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; event_valid = 1'b0; event_note_on = 1'b0;
        event_note = '0; event_velocity = '0; voice_done = '0;
        model_reset();
        do_reset();
        check("rst_active",  64'(voice_active),   64'd0);
        check("rst_notes",   64'(voice_note),     64'd0);
        check("rst_vels",    64'(voice_velocity), 64'd0);
        check("rst_pulses",  64'({voice_start, voice_release}), 64'd0);
        check("rst_ready",   64'(event_ready),    64'd1);

        // Single note lands on voice 0.
        do_event(1, 60, 100, '0);
        check("first_note0", 64'(voice_note[0]), 64'd60);

        // Fifth note steals the oldest voice.
        do_reset();
        do_event(1, 60, 100, '0); do_event(1, 62, 100, '0);
        do_event(1, 64, 100, '0); do_event(1, 65, 100, '0);
        do_event(1, 67, 100, '0);
        check("steal_note0", 64'(voice_note[0]), 64'd67);

        // Releasing voice preferred over an older held voice.
        do_reset();
        do_event(1, 60, 100, '0); do_event(1, 62, 100, '0);
        do_event(1, 64, 100, '0); do_event(1, 65, 100, '0);
        do_event(0, 62, 0, '0);
        do_event(1, 70, 100, '0);
        check("rel_pref_note1", 64'(voice_note[1]), 64'd70);

        // Retrigger same note, then velocity-0 note-on releases it.
        do_reset();
        do_event(1, 60, 50, '0);
        do_event(1, 60, 90, '0);
        check("retrig_active", 64'(voice_active), 64'b0001);
        check("retrig_vel",    64'(voice_velocity[0]), 64'd90);
        do_event(1, 60, 0, '0);

        // Unmatched note-off and done on a held voice change nothing.
        do_reset();
        do_event(1, 60, 100, '0);
        do_event(0, 72, 0, '0);
        idle_done(4'b0001);
        check("held_done_ignored", 64'(voice_active), 64'b0001);

        // voice_done in the commit cycle of a retrigger loses to the commit.
        do_reset();
        do_event(1, 60, 100, '0);
        do_event(0, 60, 0, '0);
        do_event(1, 60, 80, 4'b0001);
        check("commit_beats_done", 64'(voice_active[0]), 64'd1);

        // Reset during scan drops the event and clears outputs immediately.
        @(negedge clock);
        event_valid = 1'b1; event_note_on = 1'b1; event_note = 7'd64; event_velocity = 7'd10;
        @(negedge clock);
        event_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        model_reset();
        #1;
        check("midscan_active", 64'(voice_active), 64'd0);
        check("midscan_notes",  64'(voice_note),   64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midscan_ready", 64'(event_ready), 64'd1);
        do_event(1, 66, 20, '0);

        // Randomized traffic over a narrow note range to force matches and steals.
        for (int n = 0; n < 300; n++) begin
            bit   on   = ($urandom_range(9) < 7);
            int   note = 60 + $urandom_range(5);
            int   vel  = ($urandom_range(7) == 0) ? 0 : 1 + $urandom_range(126);
            logic [P-1:0] dc = ($urandom_range(3) == 0) ? P'($urandom_range(15)) : '0;
            do_event(on, note, vel, dc);
            if ($urandom_range(2) == 0) idle_done(P'($urandom_range(15)));
        end

        @(negedge clock);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
